// File: rtl/sample_scheduler.sv
// Two-channel waveform-table sample scheduler: round-robin arbitration of
// table reads into per-channel valid/ready holding registers, one 3-cycle transaction at a time.
module sample_scheduler #(
  parameter int N    = 32,
  parameter int size = 12,
  parameter int PW   = 16,
  localparam int AW  = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enable,
  input  logic [PW-1:0]   step0,
  input  logic [PW-1:0]   step1,
  output logic            mem_read,
  output logic [AW-1:0]   mem_address,
  input  logic [size-1:0] mem_sample,
  output logic [size-1:0] out0,
  output logic [size-1:0] out1,
  output logic            out0_valid,
  output logic            out1_valid,
  input  logic            out0_ready,
  input  logic            out1_ready,
  output logic [1:0]      dbg_state
);

  // Handshake: a sample transfers on a rising edge where outk_valid and outk_ready
  // are both 1; valid never drops without that transfer, and data is stable while valid.
  typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, CAPTURE = 2'd2} state_t;

  state_t        state, state_nxt;
  logic          grant, grant_nxt;
  logic          last;
  logic [PW-1:0] phase0, phase1;
  logic          req0, req1;
  logic [AW-1:0] addr0, addr1;

  assign req0      = !out0_valid;
  assign req1      = !out1_valid;
  assign addr0     = phase0[PW-1 -: AW];
  assign addr1     = phase1[PW-1 -: AW];
  assign mem_read  = (state == READ);
  assign dbg_state = state;

  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    case (state)
      IDLE: begin
        if (enable && (req0 || req1)) begin
          state_nxt = READ;
          // Tie goes to the channel not served last; otherwise the lone requester.
          grant_nxt = (req0 && req1) ? ~last : req1;
        end
      end
      READ:    state_nxt = CAPTURE;
      CAPTURE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      grant       <= 1'b0;
      last        <= 1'b1;
      phase0      <= '0;
      phase1      <= '0;
      mem_address <= '0;
      out0        <= '0;
      out1        <= '0;
      out0_valid  <= 1'b0;
      out1_valid  <= 1'b0;
    end else begin
      state <= state_nxt;
      grant <= grant_nxt;
      if (state == IDLE && state_nxt == READ)
        mem_address <= grant_nxt ? addr1 : addr0;
      if (out0_valid && out0_ready) out0_valid <= 1'b0;
      if (out1_valid && out1_ready) out1_valid <= 1'b0;
      // The granted channel is never valid here, so this cannot collide with a consume.
      if (state == CAPTURE) begin
        last <= grant;
        if (grant) begin
          out1       <= mem_sample;
          out1_valid <= 1'b1;
          phase1     <= phase1 + step1;
        end else begin
          out0       <= mem_sample;
          out0_valid <= 1'b1;
          phase0     <= phase0 + step0;
        end
      end
    end
  end

endmodule

// File: tb/tb_sample_scheduler.sv
// Bench for sample_scheduler: directed scenarios plus randomized traffic, all
// checked against a cycle-level behavioural model of the scheduling rules.
module tb_sample_scheduler;
  localparam int N = 32, SIZE = 12, PW = 16, AW = 5;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            enable = 1'b0;
  logic [PW-1:0]   step0 = '0, step1 = '0;
  logic            mem_read;
  logic [AW-1:0]   mem_address;
  logic [SIZE-1:0] mem_sample = '0;
  logic [SIZE-1:0] out0, out1;
  logic            out0_valid, out1_valid;
  logic            out0_ready = 1'b0, out1_ready = 1'b0;
  logic [1:0]      dbg_state;

  int total = 0;
  int bad = 0;

  logic [SIZE-1:0] tbl [N];

  sample_scheduler #(.N(N), .size(SIZE), .PW(PW)) dut (
    .clk(clk), .rst(rst), .enable(enable), .step0(step0), .step1(step1),
    .mem_read(mem_read), .mem_address(mem_address), .mem_sample(mem_sample),
    .out0(out0), .out1(out1), .out0_valid(out0_valid), .out1_valid(out1_valid),
    .out0_ready(out0_ready), .out1_ready(out1_ready), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Table returns data the cycle after a read; junk at all other times.
  initial begin : mem_model
    logic          rd;
    logic [AW-1:0] a;
    forever begin
      @(negedge clk);
      rd = mem_read;
      a  = mem_address;
      @(posedge clk);
      #1;
      mem_sample = rd ? tbl[a] : SIZE'($urandom);
    end
  end

  // ---------------- reference model ----------------
  // busy: 0 = free to grant, 1 = read cycle, 2 = capture cycle.
  int              m_busy;
  bit              m_gnt, m_last;
  bit              m_v [2];
  logic [SIZE-1:0] m_o [2];
  logic [PW-1:0]   m_ph [2];
  logic [AW-1:0]   m_addr;
  int              m_caps [2];
  bit              model_on = 1'b0;
  bit              q_on = 1'b0;
  logic [SIZE-1:0] exp_q [$];
  logic [SIZE-1:0] got0 [$];
  logic [SIZE-1:0] got1 [$];

  task automatic model_reset();
    m_busy = 0; m_gnt = 0; m_last = 1; m_addr = '0;
    for (int k = 0; k < 2; k++) begin
      m_v[k] = 0; m_o[k] = '0; m_ph[k] = '0; m_caps[k] = 0;
    end
  endtask

  task automatic model_step();
    bit cons0, cons1, g;
    check("mem_read", mem_read, (m_busy == 1));
    check("mem_address", mem_address, m_addr);
    check("out0", out0, m_o[0]);
    check("out1", out1, m_o[1]);
    check("out0_valid", out0_valid, m_v[0]);
    check("out1_valid", out1_valid, m_v[1]);
    cons0 = m_v[0] && out0_ready;
    cons1 = m_v[1] && out1_ready;
    if (cons0) got0.push_back(out0);
    if (cons1) got1.push_back(out1);
    if (q_on && cons0) begin
      if (exp_q.size() == 0) check("out0_seq_empty", 1, 0);
      else check("out0_seq", out0, exp_q.pop_front());
    end
    if (m_busy == 0) begin
      if (enable && (!m_v[0] || !m_v[1])) begin
        g = (!m_v[0] && !m_v[1]) ? !m_last : m_v[0];
        m_gnt  = g;
        m_addr = m_ph[g][PW-1 -: AW];
        m_busy = 1;
      end
    end else if (m_busy == 1) begin
      m_busy = 2;
    end else begin
      m_o[m_gnt]  = tbl[m_addr];
      m_v[m_gnt]  = 1;
      m_ph[m_gnt] = m_ph[m_gnt] + (m_gnt ? step1 : step0);
      m_last      = m_gnt;
      m_caps[m_gnt]++;
      m_busy = 0;
    end
    if (cons0) m_v[0] = 0;
    if (cons1) m_v[1] = 0;
  endtask

  initial begin : scoreboard
    forever begin
      @(negedge clk);
      if (!rst && model_on) model_step();
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    got0.delete(); got1.delete();
    check("rst_mem_read", mem_read, 0);
    check("rst_mem_address", mem_address, 0);
    check("rst_out0", out0, 0);
    check("rst_out1", out1, 0);
    check("rst_out0_valid", out0_valid, 0);
    check("rst_out1_valid", out1_valid, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic wait_caps(input int ch, input int n, input int budget, output bit to);
    to = 1;
    for (int i = 0; i < budget; i++) begin
      tick(1);
      if (m_caps[ch] >= n) begin to = 0; break; end
    end
  endtask

  task automatic wait_read(input int budget, output bit to);
    to = 1;
    for (int i = 0; i < budget; i++) begin
      tick(1);
      if (mem_read) begin to = 0; break; end
    end
  endtask

  task automatic setup(input logic en, input logic [PW-1:0] s0, input logic [PW-1:0] s1,
                       input logic r0, input logic r1);
    enable = en; step0 = s0; step1 = s1; out0_ready = r0; out1_ready = r1;
  endtask

  // ---------------- stimulus ----------------
  initial begin : main
    bit              to;
    logic [SIZE-1:0] held;
    int              n1;
    for (int i = 0; i < N; i++) tbl[i] = SIZE'(16 * i);

    do_reset();
    model_on = 1'b1;

    // Channel 0 streaming, channel 1 stuck after its first sample.
    do_reset();
    for (int i = 0; i < N; i++) exp_q.push_back(SIZE'(16 * i));
    q_on = 1'b1;
    setup(1, 16'h0800, 16'h0000, 1, 0);
    to = 1;
    for (int i = 0; i < 100; i++) begin
      tick(1);
      if (exp_q.size() <= N - 10) begin to = 0; break; end
    end
    check("stream_timeout", to, 0);
    q_on = 1'b0;
    exp_q.delete();
    check("stuck_out1", out1, 12'h000);
    check("stuck_out1_valid", out1_valid, 1);

    // Address wrap after 32 captures.
    do_reset();
    setup(1, 16'h0800, 16'h0000, 1, 0);
    wait_caps(0, 32, 300, to);
    check("wrap32_timeout", to, 0);
    check("wrap32_out0", out0, 12'h1F0);
    wait_caps(0, 33, 30, to);
    check("wrap33_timeout", to, 0);
    check("wrap33_out0", out0, 12'h000);
    wait_read(30, to);
    check("wrap_read_timeout", to, 0);
    check("wrap_next_addr", mem_address, 1);

    // Both consumers ready: alternation.
    do_reset();
    setup(1, 16'h0800, 16'h1000, 1, 1);
    tick(30);
    check("alt_got1_cnt", (got1.size() >= 3), 1);
    check("alt_got0_cnt", (got0.size() >= 3), 1);
    if (got1.size() >= 3 && got0.size() >= 3) begin
      check("alt_out1_0", got1[0], 12'h000);
      check("alt_out1_1", got1[1], 12'h020);
      check("alt_out1_2", got1[2], 12'h040);
      check("alt_out0_1", got0[1], 12'h010);
    end

    // Back-pressure on channel 0 for 20 cycles.
    do_reset();
    setup(1, 16'h0800, 16'h1000, 0, 1);
    to = 1;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (out0_valid) begin to = 0; break; end
    end
    check("stall_timeout", to, 0);
    held = out0;
    n1 = got1.size();
    for (int i = 0; i < 20; i++) begin
      tick(1);
      check("stall_out0", out0, held);
      check("stall_out0_valid", out0_valid, 1);
    end
    check("stall_ch1_served", (got1.size() >= n1 + 3), 1);
    out0_ready = 1;
    tick(10);

    // Enable dropped during READ.
    do_reset();
    setup(1, 16'h0800, 16'h1000, 1, 1);
    wait_read(20, to);
    check("en_read_timeout", to, 0);
    enable = 0;
    tick(2);
    check("en_capture_done", out0_valid | out1_valid, 1);
    for (int i = 0; i < 10; i++) begin
      tick(1);
      check("en_no_read", mem_read, 0);
    end
    enable = 1;
    wait_read(10, to);
    check("en_resume_timeout", to, 0);

    // Reset pulse between edges during CAPTURE.
    do_reset();
    setup(1, 16'h0800, 16'h1000, 1, 1);
    tick(10);
    to = 1;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (dbg_state == 2'd2) begin to = 0; break; end
    end
    check("midrst_timeout", to, 0);
    #2 rst = 1'b1;
    #1;
    check("midrst_out0", out0, 0);
    check("midrst_out1", out1, 0);
    check("midrst_valid", {out0_valid, out1_valid}, 0);
    check("midrst_read", mem_read, 0);
    check("midrst_addr", mem_address, 0);
    model_reset();
    rst = 1'b0;
    wait_read(10, to);
    check("midrst_read_timeout", to, 0);
    check("midrst_first_addr", mem_address, 0);
    tick(20);

    // Randomized traffic.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      enable     = ($urandom_range(0, 7) != 0);
      out0_ready = $urandom_range(0, 1);
      out1_ready = $urandom_range(0, 2) != 0;
      if ($urandom_range(0, 40) == 0) step0 = PW'($urandom);
      if ($urandom_range(0, 40) == 0) step1 = PW'($urandom);
      tick(1);
    end

    model_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
